mul4su_rr_arbiter: RTL
======================

# mul4su_rr_arbiter

Round-robin scheduler that shares one 4x4 signed×unsigned exact multiplier core (4-bit two's-complement `s`, 4-bit unsigned `u`, 8-bit two's-complement product) between `N_REQ` requesters. Each requester uses a valid/ready handshake. The block grants at most one request per cycle and carries operands and requester ID through a two-stage pipeline around the combinational core. It returns one tagged result per cycle on a single valid/ready output channel. It sits between the accelerator lanes and the shared multiplier core.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default `$clog2(N_REQ)`: requester-ID width; derived, not overridden.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `N_REQ`: per-requester request valid.
- `req_s` in `N_REQ*4`: packed signed operands; requester i uses `[4i+3:4i]`.
- `req_u` in `N_REQ*4`: packed unsigned operands; same packing as `req_s`.
- `req_ready` out `N_REQ`: one-hot-or-zero grant; the handshake completes when `req_valid[i] & req_ready[i]`.
- `res_valid` out 1: result valid.
- `res_data` out 8: product `s*u`, two's complement.
- `res_id` out `ID_W`: index of the requester that issued the result.
- `res_ready` in 1: downstream accept.

## Operation
- Pipeline stages:
  - Stage A: operand register `a_valid`, `a_s`, `a_u`, `a_id`.
  - Stage B: result register `res_valid`, `res_data`, `res_id`. It is loaded from the core output, driven by stage A.
- Advance conditions:
  - `b_free = !res_valid | res_ready`.
  - `a_free = !a_valid | b_free`.
- Arbitration:
  - The round-robin pointer `ptr` (`ID_W` bits) marks the highest-priority index.
  - The winner is the first i with `req_valid[i]`, scanning `ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1`.
  - `req_ready[winner] = a_free`; every other bit is 0. With no valid requests, `req_ready` is all zero.
- On a grant to requester i, stage A loads requester i's operands and `a_id=i`, and `ptr` becomes `(i+1) mod N_REQ`. With no grant, `ptr` holds.
- Stage A to B: when `a_valid & b_free`, stage B loads `res_data = core(a_s, a_u)` and `res_id = a_id`, and sets `res_valid=1`.
- Clear conditions:
  - `a_valid` clears when stage A moves to B and no new grant occurs in that cycle.
  - `res_valid` clears when `res_ready` is high and stage A is empty.
- Requesters must not make `req_valid` depend on `req_ready`. `req_ready` depends combinationally on `req_valid`, `res_valid` and `res_ready`.
- Once asserted, a requester holds `req_valid` and its operands stable until the handshake completes. The arbiter does not enforce this; the bench checks it.
- Arithmetic: `res_data = sign_extend(s) * zero_extend(u)`, truncated to 8 bits. The range is -120..105, so no overflow is possible.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - `res_valid=0`, `res_data=8'h00`, `res_id=0`.
  - `a_valid=0`, `ptr=0`.
  - While `rst` is high, `req_ready` is forced to 0.
- Latency: a handshake in cycle t produces `res_valid=1` in cycle t+2 when `res_ready` stays high.
- Throughput: 1 result per cycle with `res_ready=1`.
- Backpressure:
  - With `res_ready=0`, at most 2 requests are in flight: one in stage A, one in stage B.
  - After that, `req_ready=0`.
  - `res_data` and `res_id` stay stable while `res_valid & !res_ready`.
- Simultaneous events: in a cycle where `res_ready=1` and both stages are full, B takes A, and A takes a new grant (full-rate flow).
- Reset mid-operation: all in-flight requests are discarded with no result emitted. The arbitration order restarts at requester 0.

## Structure
- Package `mul_arb_pkg` holds:
  - `OP_W=4` and `PROD_W=8`.
  - typedef `mul_req_t` with fields `s` (signed 4-bit), `u` (4-bit) and `id`.
  - typedef `mul_res_t` with fields `data` (8-bit) and `id`.
- Sub-module `rr_pick`: combinational round-robin priority picker. It takes `req_valid` and `ptr` and outputs `grant_vld` and `grant_idx`. It is parameterised on `N_REQ`.
- The multiplier core is instantiated unmodified between stage A and stage B.

## Test plan
- Single request: requester 0 issues `s=4'b1001` (-7), `u=15` in cycle t → `res_valid` in cycle t+2 with `res_data=8'h97` (-105) and `res_id=0`.
- Fairness: all 4 requesters valid continuously with `res_ready=1` → grant order 0,1,2,3,0,1,…, one result per cycle, IDs in the same order.
- Backpressure: continuous requests with `res_ready=0` for 5 cycles → exactly 2 handshakes, then `req_ready=0`. `res_data` and `res_id` stay stable. On release, results drain in order with no loss or duplication.
- Corners via requester 3:
  - `s=-8`, `u=15` → `8'h88`.
  - `s=7`, `u=15` → `8'h69`.
  - `s=-1`, `u=1` → `8'hFF`.
  - `s=0`, `u=9` → `8'h00`.
- Reset mid-stream: both stages full and `ptr=2`, then `rst` high for 1 cycle → next cycle `res_valid=0`, and the first subsequent grant goes to the lowest-index valid requester starting at 0.
- Exhaustive: all 256 (s,u) pairs through requester 2 with random `res_ready` stalls → every `res_data` matches the golden `s*u` model, and `res_id=2` throughout.

Source files
------------

// File: rtl/mul4su_rr_arbiter_pkg.sv
// Shared widths and transaction records for the round-robin shared-multiplier scheduler.
// The ID field is sized for the largest legal requester count (8).
package mul_arb_pkg;
  localparam int OP_W     = 4;
  localparam int PROD_W   = 8;
  localparam int MAX_ID_W = 3;

  typedef struct packed {
    logic signed [OP_W-1:0] s;
    logic [OP_W-1:0]        u;
    logic [MAX_ID_W-1:0]    id;
  } mul_req_t;

  typedef struct packed {
    logic [PROD_W-1:0]   data;
    logic [MAX_ID_W-1:0] id;
  } mul_res_t;
endpackage

// File: rtl/mul4su_rr_arbiter_core.sv
// Exact 4x4 signed-by-unsigned multiplier, 8-bit two's-complement product.
// Purely combinational; product range -120..105 always fits.
module mul4su_core
  import mul_arb_pkg::*;
(
  input  logic signed [OP_W-1:0] i_s,
  input  logic [OP_W-1:0]        i_u,
  output logic [PROD_W-1:0]      o_p
);
  logic signed [PROD_W-1:0] w_s_ext;
  logic signed [PROD_W-1:0] w_u_ext;

  assign w_s_ext = {{(PROD_W-OP_W){i_s[OP_W-1]}}, i_s};
  assign w_u_ext = {{(PROD_W-OP_W){1'b0}}, i_u};
  assign o_p     = w_s_ext * w_u_ext;
endmodule

// File: rtl/mul4su_rr_arbiter_pick.sv
// Combinational round-robin picker: first valid index scanning ptr, ptr+1, ... wrapping at N_REQ.
// Zero latency; no state, no backpressure of its own.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  ptr,
  output logic             grant_vld,
  output logic [ID_W-1:0]  grant_idx
);
  logic [ID_W:0] w_sum;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    w_sum     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // Modular add kept one bit wider so non-power-of-two N_REQ wraps correctly.
      w_sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(N_REQ)) w_sum = w_sum - (ID_W+1)'(N_REQ);
      if (!grant_vld && req_valid[w_sum[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = w_sum[ID_W-1:0];
      end
    end
  end
endmodule

// File: rtl/mul4su_rr_arbiter.sv
// Round-robin share of one 4x4 s*u multiplier; grant -> stage A -> stage B, result 2 cycles after handshake.
// Holds at most two requests in flight; req_ready drops once both stages are full and res_ready is low.
module mul4su_rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*OP_W-1:0]  req_s,
  input  logic [N_REQ*OP_W-1:0]  req_u,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   res_valid,
  output logic [PROD_W-1:0]      res_data,
  output logic [ID_W-1:0]        res_id,
  input  logic                   res_ready
);
  mul_req_t          r_a;
  logic              r_a_valid;
  logic [ID_W-1:0]   r_ptr;
  mul_res_t          r_res;
  logic              r_res_valid;

  logic              w_b_free;
  logic              w_a_free;
  logic              w_a_to_b;
  logic              w_grant_vld;
  logic [ID_W-1:0]   w_grant_idx;
  logic              w_grant;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [OP_W-1:0]   w_sel_s;
  logic [OP_W-1:0]   w_sel_u;
  logic [PROD_W-1:0] w_prod;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req_valid (req_valid),
    .ptr       (r_ptr),
    .grant_vld (w_grant_vld),
    .grant_idx (w_grant_idx)
  );

  mul4su_core u_core (
    .i_s (r_a.s),
    .i_u (r_a.u),
    .o_p (w_prod)
  );

  assign w_b_free  = !r_res_valid || res_ready;
  assign w_a_free  = !r_a_valid || w_b_free;
  assign w_a_to_b  = r_a_valid && w_b_free;
  // Reset masks the grant so no handshake can complete while state is being cleared.
  assign w_grant   = w_grant_vld && w_a_free && !rst;
  assign w_ptr_nxt = (w_grant_idx == ID_W'(N_REQ-1)) ? '0 : w_grant_idx + ID_W'(1);
  assign w_sel_s   = req_s[{w_grant_idx, 2'b00} +: OP_W];
  assign w_sel_u   = req_u[{w_grant_idx, 2'b00} +: OP_W];

  always_comb begin
    req_ready = '0;
    if (w_grant) req_ready[w_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid   <= 1'b0;
      r_a         <= '0;
      r_ptr       <= '0;
      r_res_valid <= 1'b0;
      r_res       <= '0;
    end else begin
      if (w_grant) begin
        r_a_valid <= 1'b1;
        r_a.s     <= w_sel_s;
        r_a.u     <= w_sel_u;
        r_a.id    <= MAX_ID_W'(w_grant_idx);
        r_ptr     <= w_ptr_nxt;
      end else if (w_a_to_b) begin
        r_a_valid <= 1'b0;
      end

      if (w_a_to_b) begin
        r_res_valid <= 1'b1;
        r_res.data  <= w_prod;
        r_res.id    <= r_a.id;
      end else if (res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res.data;
  assign res_id    = ID_W'(r_res.id);
endmodule
